// File: rtl/laundry_pkg.sv
// Shared definitions for the laundry scheduler.
// Holds the scheduler state encoding, the usage counter width and the default
// values for the user count and the start watchdog.
package laundry_pkg;

    // Scheduler states, kept as plain 2-bit constants for legacy tooling.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam int unsigned USAGE_W           = 16;
    localparam int unsigned DEF_NUM_USERS     = 4;
    localparam int unsigned DEF_START_TIMEOUT = 8;

endpackage

// File: rtl/laundry_scheduler_rr_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   req_i   - per-user request vector
//   ptr_i   - index holding the highest priority this round
//   valid_o - at least one request is pending
//   idx_o   - first requesting index found searching upward from ptr_i, wrapping
module rr_pick #(
    parameter int unsigned NUM_USERS = 4,
    parameter int unsigned PTR_W     = 2
) (
    input  logic [NUM_USERS-1:0] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic                 valid_o,
    output logic [PTR_W-1:0]     idx_o
);

    int unsigned pos;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        for (int unsigned i = 0; i < NUM_USERS; i++) begin
            pos = (32'(ptr_i) + i) % NUM_USERS;
            if (!valid_o && req_i[pos]) begin
                valid_o = 1'b1;
                idx_o   = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/laundry_scheduler.sv
// Round-robin scheduler sharing one washing-machine controller among
// NUM_USERS requesters. Grants a pending user, drives start and the wash
// options to the machine, follows mach_done_i through the run and releases.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   req_i               - level request per user
//   req_double_i/dry_i  - per-user options, sampled at grant
//   mach_done_i         - machine idle/available
//   mach_start_o, mach_double_wash_o, mach_dry_wash_o - machine controls
//   grant_o             - one-hot owner, zero when free
//   busy_o              - scheduler not idle
//   cycle_done_o        - pulse when the owner's run completes
//   err_timeout_o       - pulse when the machine never accepted start
//   usage_cnt_o         - per-user saturating run counters, only when
//                         LAUNDRY_SCHED_USAGE_CNT_EN is defined
module laundry_scheduler
    import laundry_pkg::*;
#(
    parameter int unsigned NUM_USERS     = DEF_NUM_USERS,
    parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_USERS-1:0] req_i,
    input  logic [NUM_USERS-1:0] req_double_i,
    input  logic [NUM_USERS-1:0] req_dry_i,
    input  logic                 mach_done_i,
    output logic                 mach_start_o,
    output logic                 mach_double_wash_o,
    output logic                 mach_dry_wash_o,
    output logic [NUM_USERS-1:0] grant_o,
    output logic                 busy_o,
    output logic                 cycle_done_o,
    output logic                 err_timeout_o
`ifdef LAUNDRY_SCHED_USAGE_CNT_EN
    ,
    output logic [NUM_USERS*USAGE_W-1:0] usage_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_USERS);
    localparam int unsigned WD_W  = $clog2(START_TIMEOUT + 1);

    logic [1:0]           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [WD_W-1:0]      wd_q, wd_d, wd_inc;
    logic [NUM_USERS-1:0] grant_q, grant_d;
    logic                 start_q, start_d;
    logic                 dbl_q, dbl_d;
    logic                 dry_q, dry_d;
    logic                 busy_q, busy_d;
    logic                 cdone_q, cdone_d;
    logic                 err_q, err_d;
    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     next_owner;

    rr_pick #(
        .NUM_USERS (NUM_USERS),
        .PTR_W     (PTR_W)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign next_owner = (owner_q == PTR_W'(NUM_USERS - 1)) ? '0 : owner_q + PTR_W'(1);
    assign wd_inc     = wd_q + WD_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wd_d    = wd_q;
        grant_d = grant_q;
        start_d = start_q;
        dbl_d   = dbl_q;
        dry_d   = dry_q;
        cdone_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // An unavailable machine blocks arbitration regardless of requests.
                if (mach_done_i && pick_valid) begin
                    owner_d = pick_idx;
                    grant_d = NUM_USERS'(1) << pick_idx;
                    start_d = 1'b1;
                    dbl_d   = req_double_i[pick_idx];
                    dry_d   = req_dry_i[pick_idx];
                    wd_d    = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // Machine acceptance wins over a simultaneous watchdog expiry.
                if (!mach_done_i) begin
                    start_d = 1'b0;
                    state_d = S_RUN;
                end else if (wd_inc == WD_W'(START_TIMEOUT)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    start_d = 1'b0;
                    dbl_d   = 1'b0;
                    dry_d   = 1'b0;
                    ptr_d   = next_owner;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_RUN: begin
                // Options stay asserted: the machine re-samples them every rinse.
                if (mach_done_i) begin
                    cdone_d = 1'b1;
                    grant_d = '0;
                    dbl_d   = 1'b0;
                    dry_d   = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                ptr_d   = next_owner;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            wd_q    <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            dbl_q   <= 1'b0;
            dry_q   <= 1'b0;
            busy_q  <= 1'b0;
            cdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wd_q    <= wd_d;
            grant_q <= grant_d;
            start_q <= start_d;
            dbl_q   <= dbl_d;
            dry_q   <= dry_d;
            busy_q  <= busy_d;
            cdone_q <= cdone_d;
            err_q   <= err_d;
        end
    end

    assign mach_start_o       = start_q;
    assign mach_double_wash_o = dbl_q;
    assign mach_dry_wash_o    = dry_q;
    assign grant_o            = grant_q;
    assign busy_o             = busy_q;
    assign cycle_done_o       = cdone_q;
    assign err_timeout_o      = err_q;

`ifdef LAUNDRY_SCHED_USAGE_CNT_EN
    logic [USAGE_W-1:0] usage_q [NUM_USERS];

    // Counted on the same edge that raises cycle_done; timeouts never count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned u = 0; u < NUM_USERS; u++) begin
                usage_q[u] <= '0;
            end
        end else begin
            for (int unsigned u = 0; u < NUM_USERS; u++) begin
                if (cdone_d && (owner_q == PTR_W'(u)) && (usage_q[u] != '1)) begin
                    usage_q[u] <= usage_q[u] + USAGE_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_USERS; g++) begin : g_usage
        assign usage_cnt_o[g*USAGE_W +: USAGE_W] = usage_q[g];
    end
`endif

endmodule

// File: tb/tb_laundry_scheduler.sv
// Self-checking bench for laundry_scheduler: a behavioural washing machine,
// random requesters and a transaction-level reference of the arbitration rules.
module tb_laundry_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned T = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] req_double;
    logic [N-1:0] req_dry;
    logic         mach_done;
    logic         mach_start;
    logic         mach_double_wash;
    logic         mach_dry_wash;
    logic [N-1:0] grant;
    logic         busy;
    logic         cycle_done;
    logic         err_timeout;
`ifdef LAUNDRY_SCHED_USAGE_CNT_EN
    logic [N*16-1:0] usage_cnt;
`endif

    laundry_scheduler #(
        .NUM_USERS     (N),
        .START_TIMEOUT (T)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_i              (req),
        .req_double_i       (req_double),
        .req_dry_i          (req_dry),
        .mach_done_i        (mach_done),
        .mach_start_o       (mach_start),
        .mach_double_wash_o (mach_double_wash),
        .mach_dry_wash_o    (mach_dry_wash),
        .grant_o            (grant),
        .busy_o             (busy),
        .cycle_done_o       (cycle_done),
        .err_timeout_o      (err_timeout)
`ifdef LAUNDRY_SCHED_USAGE_CNT_EN
        ,
        .usage_cnt_o        (usage_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the machine and in which phase of its run.
    int m_ptr;
    bit m_active;
    bit m_run;
    bit m_cool;
    int m_owner;
    int m_t;
    bit m_dbl;
    bit m_dry;
    int m_usage [N];

    // Machine model.
    bit mc_rand;
    bit mc_force_ignore;
    bit mc_ignore;
    int mc_left;

    task automatic model_reset();
        m_ptr = 0;
        m_active = 0;
        m_run = 0;
        m_cool = 0;
        m_owner = 0;
        m_t = 0;
        m_dbl = 0;
        m_dry = 0;
        for (int u = 0; u < N; u++) m_usage[u] = 0;
        mc_ignore = 0;
        mc_left = 0;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'(0));
        check({tag, "_start"}, 64'(mach_start), 64'(0));
        check({tag, "_dbl"}, 64'(mach_double_wash), 64'(0));
        check({tag, "_dry"}, 64'(mach_dry_wash), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_cdone"}, 64'(cycle_done), 64'(0));
        check({tag, "_err"}, 64'(err_timeout), 64'(0));
`ifdef LAUNDRY_SCHED_USAGE_CNT_EN
        check({tag, "_usage"}, 64'(usage_cnt), 64'(0));
`endif
    endtask

    // Advance the reference over one clock edge that saw the given inputs,
    // then compare every DUT output.
    task automatic check_edge(input logic [N-1:0] r, input logic [N-1:0] d,
                              input logic [N-1:0] y, input logic done);
        logic [N-1:0] e_grant;
        bit e_start, e_cd, e_err;
        int w;
        e_cd = 0;
        e_err = 0;
        if (!m_active) begin
            if (!m_cool && done && (r != '0)) begin
                w = pick(r, m_ptr);
                m_active = 1;
                m_run = 0;
                m_owner = w;
                m_t = 0;
                m_dbl = d[w];
                m_dry = y[w];
            end
        end else if (!m_run) begin
            m_t++;
            if (!done) begin
                m_run = 1;
            end else if (m_t == int'(T)) begin
                e_err = 1;
                m_active = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end else if (done) begin
            e_cd = 1;
            m_active = 0;
            if (m_usage[m_owner] < 65535) m_usage[m_owner]++;
            m_ptr = (m_owner + 1) % N;
        end
        m_cool = e_cd;
        e_grant = '0;
        if (m_active) e_grant[m_owner] = 1'b1;
        e_start = m_active && !m_run;
        check("grant", 64'(grant), 64'(e_grant));
        check("start", 64'(mach_start), 64'(e_start));
        check("dbl", 64'(mach_double_wash), 64'(m_active ? m_dbl : 1'b0));
        check("dry", 64'(mach_dry_wash), 64'(m_active ? m_dry : 1'b0));
        check("busy", 64'(busy), 64'(m_active || e_cd));
        check("cycle_done", 64'(cycle_done), 64'(e_cd));
        check("err_timeout", 64'(err_timeout), 64'(e_err));
`ifdef LAUNDRY_SCHED_USAGE_CNT_EN
        for (int u = 0; u < N; u++) begin
            check($sformatf("usage%0d", u), 64'(usage_cnt[u*16 +: 16]), 64'(m_usage[u]));
        end
`endif
    endtask

    // Machine reacts to what it saw at the edge just taken.
    task automatic machine_update(input logic pre_start, input logic pre_done);
        if (pre_done && pre_start && !mc_ignore) begin
            mach_done = 1'b0;
            mc_left = int'($urandom_range(2, 12));
        end else if (!pre_done) begin
            if (mc_left <= 1) mach_done = 1'b1;
            else mc_left--;
        end else if (mc_rand && !pre_start && ($urandom_range(0, 15) == 0)) begin
            mach_done = 1'b0;
            mc_left = int'($urandom_range(1, 3));
        end
        // Acceptance behaviour only changes while no start is pending.
        if (!pre_start) mc_ignore = mc_rand ? ($urandom_range(0, 4) == 0) : mc_force_ignore;
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N-1:0] y);
        logic pre_start, pre_done;
        req = r;
        req_double = d;
        req_dry = y;
        pre_start = mach_start;
        pre_done = mach_done;
        @(posedge clk);
        #1;
        check_edge(r, d, y, pre_done);
        machine_update(pre_start, pre_done);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (m_active || m_cool); i++) step('0, '0, '0);
        check(tag, 64'(busy), 64'(0));
    endtask

    logic [N-1:0] rr;
    logic [N-1:0] rd;
    logic [N-1:0] ry;

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        req = '0;
        req_double = '0;
        req_dry = '0;
        mach_done = 1'b1;
        mc_rand = 0;
        mc_force_ignore = 0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, full run.
        step(4'b0001, 4'b0000, 4'b0001);
        drain("single_idle");

        // All requesting: strict rotation over several runs.
        for (int i = 0; i < 100; i++) step(4'b1111, 4'b1010, 4'b0101);
        drain("rotate_idle");

        // Double-wash option held through the run.
        step(4'b0100, 4'b0100, 4'b0000);
        for (int i = 0; i < 40 && (m_active || m_cool); i++) step(4'b0100, 4'b0100, 4'b0000);
        drain("double_idle");

        // Machine ignores start: watchdog fires, next requester gets served.
        mc_force_ignore = 1;
        mc_ignore = 1;
        for (int i = 0; i < 9; i++) step(4'b0011, 4'b0000, 4'b0000);
        mc_force_ignore = 0;
        for (int i = 0; i < 40; i++) step(4'b0011, 4'b0000, 4'b0000);
        drain("timeout_idle");

        // Reset in the middle of a run.
        step(4'b0100, 4'b0000, 4'b0100);
        for (int i = 0; i < 20 && !m_run; i++) step(4'b0000, 4'b0000, 4'b0000);
        check("mid_run_busy", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        mach_done = 1'b1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1001, 4'b0000, 4'b0000);
        drain("after_reset_idle");

        // Random traffic with a randomly misbehaving machine.
        mc_rand = 1;
        rr = '0;
        rd = '0;
        ry = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rr = N'($urandom);
            if ($urandom_range(0, 63) == 0) rr = '1;
            rd = N'($urandom);
            ry = N'($urandom);
            step(rr, rd, ry);
        end
        mc_rand = 0;
        mc_force_ignore = 0;
        drain("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/laundry_scheduler.md
# laundry_scheduler

Round-robin scheduler that shares one washing-machine controller among NUM_USERS requesters. It picks one pending requester and drives the machine's start, double-wash and dry-wash controls with that user's options. It then tracks the run through the machine's done output and releases the machine when the cycle ends. It sits between the user panels and the machine instance; the machine receives the same clk and rst_n.

## Interface
- NUM_USERS, default 4: number of requesters; range 2..16.
- START_TIMEOUT, default 8: maximum cycles to wait for mach_done to fall after start; range 1..255.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_USERS  level request per user.
- req_double  in  NUM_USERS  per-user double-wash option; sampled at grant.
- req_dry  in  NUM_USERS  per-user steam/dry-clean option; sampled at grant.
- mach_done  in  1  machine done: 1 = machine in IDLE/available.
- mach_start  out  1  start to the machine.
- mach_double_wash  out  1  double-wash option to the machine.
- mach_dry_wash  out  1  dry-wash option to the machine.
- grant  out  NUM_USERS  one-hot owner of the machine; all zero when free.
- busy  out  1  scheduler is not in S_IDLE.
- cycle_done  out  1  one-cycle pulse when the owner's run completes.
- err_timeout  out  1  one-cycle pulse when the machine failed to accept start.

## Operation
- All outputs are registered. Reset value of every output is 0; ptr=0; state=S_IDLE; watchdog=0.
- S_IDLE
  - When mach_done=1 and |req, select the winner: the first set bit of req, searching from ptr upward modulo NUM_USERS.
  - Latch owner, req_double[owner] and req_dry[owner].
  - Set grant=onehot(owner), mach_start=1 and both option outputs, then go to S_START.
  - If mach_done=0, no grant is issued, whatever req is.
- S_START
  - Hold mach_start=1 and the options; watchdog increments each cycle.
  - mach_done=0 → drop mach_start; go to S_RUN.
  - Watchdog reaches START_TIMEOUT with mach_done still 1:
    - pulse err_timeout; clear grant, mach_start and the options;
    - ptr=owner+1 mod NUM_USERS; go to S_IDLE.
- S_RUN
  - mach_double_wash and mach_dry_wash stay held, because the machine samples double_wash at the end of every rinse.
  - mach_done=1 → go to S_RELEASE.
- S_RELEASE, one cycle:
  - pulse cycle_done; clear grant and the options;
  - ptr=owner+1 mod NUM_USERS; go to S_IDLE.
- Requester deasserts req after grant: no effect; the run completes and is counted.
- Request arrives while busy: it waits; the next arbitration includes it.
- Only bit ptr set, or only a bit below ptr set: the modulo wrap still grants it.
- Simultaneous requests: strict rotation. Each user is served at most once per NUM_USERS grants while others are pending.
- rst_n low at any time: return to reset values immediately. There is no partial-run bookkeeping.

## Timing
- Arbitration latency: req seen in S_IDLE at edge k → grant and mach_start high after edge k.
- The machine leaves IDLE at edge k+1, so mach_done falls after k+1.
- S_START lasts one cycle nominally.
- mach_done rising at edge m → cycle_done high for the cycle after m+1; a new grant follows at the earliest one cycle later.
- Watchdog width: ceil(log2(START_TIMEOUT+1)) bits. err_timeout fires START_TIMEOUT cycles after entering S_START.

## Configuration
- LAUNDRY_SCHED_USAGE_CNT_EN defined:
  - adds output usage_cnt, width NUM_USERS*16;
  - one 16-bit saturating counter per user, incremented with cycle_done for the owner;
  - counters hold at 16'hFFFF;
  - counters are not incremented on err_timeout;
  - counters reset to 0.
- LAUNDRY_SCHED_USAGE_CNT_EN undefined: the port and counters do not exist; all other behaviour is identical.

## Structure
- Shared package laundry_pkg:
  - scheduler state encoding: S_IDLE, S_START, S_RUN, S_RELEASE (2 bits);
  - USAGE_W=16;
  - default NUM_USERS and START_TIMEOUT values.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req, ptr.
  - Outputs: valid and winner index.
  - Instantiated once.

## Test plan
- req=4'b0001, mach_done model returns to 1 after 20 cycles → grant=0001 and mach_start one cycle after req; cycle_done pulses once; grant back to 0; ptr=1.
- req=4'b1111 held for four full runs → grant order 0001, 0010, 0100, 1000, then 0001 again.
- req=4'b0100, req_double=4'b0100 → mach_double_wash=1 from grant through S_RUN; cleared in S_RELEASE.
- Machine model ignores start, mach_done stuck at 1, START_TIMEOUT=8 → err_timeout pulses 8 cycles after S_START entry; grant cleared; next requester served.
- rst_n low during S_RUN → all outputs 0 immediately; after release, a new req re-arbitrates from ptr=0.
- LAUNDRY_SCHED_USAGE_CNT_EN defined, user 2 completes 3 runs → usage_cnt[47:32]=3; counter preloaded to 16'hFFFF stays at 16'hFFFF.
